// File: rtl/example_differentiator_pkg.sv
// Shared definitions for the PID-path filters: controller state encoding and
// accumulator sizing used by the differentiator and the trapezoidal integrator.
package example_differentiator_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      DIFF  = 3'd1,
      MUL_D = 3'd2,
      MUL_A = 3'd3,
      SAT   = 3'd4
   } ctrl_state_t;

   // Accumulator holds a full coefficient product on the state scale plus two guard bits.
   function automatic int acc_width(input int dw, input int cf, input int cw);
      return dw + cf + cw + 2;
   endfunction

   function automatic int state_width(input int dw, input int cf);
      return dw + cf;
   endfunction

endpackage

// File: rtl/example_differentiator_ctrl_saturate.sv
// Parameterised signed clamp from a wide accumulator down to OW bits
// (MAX = 2^(OW-1)-1, MIN = -2^(OW-1)); shared with the integrator overflow logic.
module example_differentiator_ctrl_saturate #(
   parameter int IW = 58,
   parameter int OW = 40
) (
   input  logic [IW-1:0] din,
   output logic [OW-1:0] dout
);

   localparam logic [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
   localparam logic [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

   logic signed [IW-1:0] max_ext;
   logic signed [IW-1:0] min_ext;
   logic signed [IW-1:0] din_s;

   assign max_ext = {{(IW-OW){1'b0}}, OMAX};
   assign min_ext = {{(IW-OW){1'b1}}, OMIN};
   assign din_s   = din;

   // Clamp to the representable output range.
   always_comb begin
      dout = din[OW-1:0];
      if (din_s > max_ext) begin
         dout = OMAX;
      end else if (din_s < min_ext) begin
         dout = OMIN;
      end else begin
         dout = din[OW-1:0];
      end
   end

endmodule

// File: rtl/example_differentiator.sv
// Filtered differentiator y[n] = AP*y[n-1] + KD*(u[n]-u[n-1]) with one shared multiplier.
// Optional sticky overrun flag: define EXAMPLE_DIFFERENTIATOR_OVERRUN_EN.
module example_differentiator
   import example_differentiator_pkg::*;
#(
   parameter int                     DW = 24,
   parameter int                     CW = 16,
   parameter int                     CF = 16,
   parameter logic signed [CW-1:0]   KD = 16'sd1024,
   parameter logic signed [CW-1:0]   AP = 16'sd0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          ce_in,
   input  logic [DW-1:0] sig_in,
   output logic          ce_out,
   output logic [DW-1:0] sig_out,
   output logic          busy
`ifdef EXAMPLE_DIFFERENTIATOR_OVERRUN_EN
   ,
   output logic          overrun
`endif
);

   localparam int YW  = state_width(DW, CF);
   localparam int AW  = acc_width(DW, CF, CW);
   localparam int DUW = DW + 1;
   localparam int PW  = CW + YW;

   ctrl_state_t state, next_state;

   logic signed [DW-1:0]  un;
   logic signed [DW-1:0]  u_prev;
   logic signed [DUW-1:0] du;
   logic signed [AW-1:0]  acc;
   logic signed [YW-1:0]  yn;
   logic [YW-1:0]         sat_out;

   logic signed [CW-1:0]  mul_coef;
   logic signed [YW-1:0]  mul_data;
   logic signed [PW-1:0]  mul_prod;
   logic signed [AW-1:0]  prod_ext;
   logic signed [AW-1:0]  pole_ext;

   // Operand select for the single multiplier: KD*du in MUL_D, AP*yn in MUL_A.
   always_comb begin
      mul_coef = KD;
      mul_data = YW'(du);
      if (state == MUL_A) begin
         mul_coef = AP;
         mul_data = yn;
      end else begin
         mul_coef = KD;
         mul_data = YW'(du);
      end
   end

   assign mul_prod = PW'(mul_coef) * PW'(mul_data);
   assign prod_ext = AW'(mul_prod);
   // Arithmetic shift truncates toward -inf, so negative decays round down.
   assign pole_ext = AW'(mul_prod >>> CF);

   example_differentiator_ctrl_saturate #(
      .IW (AW),
      .OW (YW)
   ) u_sat (
      .din  (acc),
      .dout (sat_out)
   );

   // State register and registered busy flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
      end else begin
         state <= next_state;
         busy  <= (next_state != IDLE);
      end
   end

   // Next-state sequencing; a strobe outside IDLE is ignored.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (ce_in) begin
               next_state = DIFF;
            end else begin
               next_state = IDLE;
            end
         end
         DIFF:    next_state = MUL_D;
         MUL_D:   next_state = MUL_A;
         MUL_A:   next_state = SAT;
         SAT:     next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Datapath: one operation per state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         un     <= '0;
         u_prev <= '0;
         du     <= '0;
         acc    <= '0;
         yn     <= '0;
         ce_out <= 1'b0;
      end else begin
         ce_out <= 1'b0;
         case (state)
            IDLE: begin
               if (ce_in) begin
                  un <= sig_in;
               end
            end
            DIFF: begin
               du     <= DUW'(un) - DUW'(u_prev);
               u_prev <= un;
            end
            MUL_D: acc <= prod_ext;
            MUL_A: acc <= acc + pole_ext;
            SAT: begin
               // The stored state itself is clamped so the pole cannot wind up.
               yn     <= sat_out;
               ce_out <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign sig_out = yn[YW-1:CF];

`ifdef EXAMPLE_DIFFERENTIATOR_OVERRUN_EN
   // Sticky record of any strobe that arrived while a sample was in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         overrun <= 1'b0;
      end else if (ce_in && busy) begin
         overrun <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_example_differentiator.sv
// Directed bench: default (AP=0), pole (AP=0.5, CW=18) and saturation (CF=8, KD=10.0) builds.
module tb_example_differentiator;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                ce_in   [3];
   logic signed [23:0]  sig_in  [3];
   logic                ce_out  [3];
   logic signed [23:0]  sig_out [3];
   logic                busy    [3];
`ifdef EXAMPLE_DIFFERENTIATOR_OVERRUN_EN
   logic                overrun [3];
`endif

   int passes = 0;
   int checks = 0;

   always #5 clk = ~clk;

   example_differentiator #(.DW(24), .CW(16), .CF(16), .KD(16'sd1024), .AP(16'sd0)) u_dut (
      .clk(clk), .rst_n(rst_n), .ce_in(ce_in[0]), .sig_in(sig_in[0]),
      .ce_out(ce_out[0]), .sig_out(sig_out[0]), .busy(busy[0])
`ifdef EXAMPLE_DIFFERENTIATOR_OVERRUN_EN
      , .overrun(overrun[0])
`endif
   );

   example_differentiator #(.DW(24), .CW(18), .CF(16), .KD(18'sd1024), .AP(18'sd32768)) u_pole (
      .clk(clk), .rst_n(rst_n), .ce_in(ce_in[1]), .sig_in(sig_in[1]),
      .ce_out(ce_out[1]), .sig_out(sig_out[1]), .busy(busy[1])
`ifdef EXAMPLE_DIFFERENTIATOR_OVERRUN_EN
      , .overrun(overrun[1])
`endif
   );

   example_differentiator #(.DW(24), .CW(16), .CF(8), .KD(16'sd2560), .AP(16'sd0)) u_sat (
      .clk(clk), .rst_n(rst_n), .ce_in(ce_in[2]), .sig_in(sig_in[2]),
      .ce_out(ce_out[2]), .sig_out(sig_out[2]), .busy(busy[2])
`ifdef EXAMPLE_DIFFERENTIATOR_OVERRUN_EN
      , .overrun(overrun[2])
`endif
   );

   task automatic check(input string tag, input logic signed [63:0] obs,
                        input logic signed [63:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Strobe one sample; returns at the falling edge right after it was accepted.
   task automatic launch(input int d, input logic signed [23:0] v);
      @(negedge clk);
      ce_in[d]  = 1'b1;
      sig_in[d] = v;
      @(negedge clk);
      ce_in[d]  = 1'b0;
   endtask

   // From 'skip' cycles after acceptance: busy through SAT, then a single ce_out with the result.
   task automatic expect_result(input int d, input logic signed [23:0] exp,
                                input string tag, input int skip);
      for (int p = skip; p < 4; p++) begin
         check({tag, "_busy"}, 64'(busy[d]), 64'sd1);
         check({tag, "_ce_early"}, 64'(ce_out[d]), 64'sd0);
         @(negedge clk);
      end
      check({tag, "_ce"}, 64'(ce_out[d]), 64'sd1);
      check({tag, "_idle"}, 64'(busy[d]), 64'sd0);
      check({tag, "_val"}, sig_out[d], exp);
      @(negedge clk);
      check({tag, "_ce_pulse"}, 64'(ce_out[d]), 64'sd0);
      check({tag, "_hold"}, sig_out[d], exp);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic signed [23:0] pole_pos [5];
      logic signed [23:0] pole_neg [5];
      pole_pos = '{24'sd1000, 24'sd500, 24'sd250, 24'sd125, 24'sd62};
      pole_neg = '{-24'sd1000, -24'sd500, -24'sd250, -24'sd125, -24'sd63};

      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         ce_in[i]  = 1'b0;
         sig_in[i] = '0;
      end
      #3;
      for (int i = 0; i < 3; i++) begin
         check("rst_sig_out", sig_out[i], 64'sd0);
         check("rst_ce_out", 64'(ce_out[i]), 64'sd0);
         check("rst_busy", 64'(busy[i]), 64'sd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Step with AP=0: one impulse of 64000/64, then nothing.
      launch(0, 24'sd64000);
      expect_result(0, 24'sd1000, "step1", 0);
      launch(0, 24'sd64000);
      expect_result(0, 24'sd0, "step2", 0);

      // Second strobe two cycles into the computation is dropped.
`ifdef EXAMPLE_DIFFERENTIATOR_OVERRUN_EN
      check("ovr_before", 64'(overrun[0]), 64'sd0);
`endif
      launch(0, 24'sd32000);
      @(negedge clk);
      ce_in[0]  = 1'b1;
      sig_in[0] = 24'sd99999;
      @(negedge clk);
      ce_in[0]  = 1'b0;
      expect_result(0, -24'sd500, "overrun", 2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("ovr_no_restart", 64'(busy[0]), 64'sd0);
         check("ovr_no_extra_ce", 64'(ce_out[0]), 64'sd0);
      end
`ifdef EXAMPLE_DIFFERENTIATOR_OVERRUN_EN
      check("ovr_set", 64'(overrun[0]), 64'sd1);
      check("ovr_other_dut", 64'(overrun[1]), 64'sd0);
`endif

      // Strobe during SAT is dropped; the strobe one cycle later is taken.
      launch(0, 24'sd0);
      for (int p = 0; p < 3; p++) @(negedge clk);
      ce_in[0]  = 1'b1;
      sig_in[0] = 24'sd6400000;
      @(negedge clk);
      check("b2b_ce", 64'(ce_out[0]), 64'sd1);
      check("b2b_val", sig_out[0], -64'sd500);
      check("b2b_sat_dropped", 64'(busy[0]), 64'sd0);
      sig_in[0] = 24'sd64000;
      @(negedge clk);
      ce_in[0]  = 1'b0;
      expect_result(0, 24'sd1000, "b2b_next", 0);
`ifdef EXAMPLE_DIFFERENTIATOR_OVERRUN_EN
      check("ovr_sticky", 64'(overrun[0]), 64'sd1);
`endif

      // Asynchronous reset while the sample sits in MUL_A.
      launch(0, 24'sd128000);
      @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_sig_out", sig_out[0], 64'sd0);
      check("midrst_ce_out", 64'(ce_out[0]), 64'sd0);
      check("midrst_busy", 64'(busy[0]), 64'sd0);
`ifdef EXAMPLE_DIFFERENTIATOR_OVERRUN_EN
      check("midrst_overrun", 64'(overrun[0]), 64'sd0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      launch(0, 24'sd64000);
      expect_result(0, 24'sd1000, "post_reset", 0);

      // Pole at 0.5: geometric decay, truncating toward -inf on the negative side.
      do_reset();
      for (int k = 0; k < 5; k++) begin
         launch(1, 24'sd64000);
         expect_result(1, pole_pos[k], "pole_pos", 0);
      end
      do_reset();
      for (int k = 0; k < 5; k++) begin
         launch(1, -24'sd64000);
         expect_result(1, pole_neg[k], "pole_neg", 0);
      end

      // Gain 10 with CF=8 overflows the state in both directions.
      do_reset();
      launch(2, 24'sd1000000);
      expect_result(2, 24'sd8388607, "sat_pos", 0);
      check("sat_pos_state", u_sat.yn, 64'sd2147483647);
      launch(2, 24'sd0);
      expect_result(2, -24'sd8388608, "sat_neg", 0);
      check("sat_neg_state", u_sat.yn, -64'sd2147483648);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
